// File: rtl/control_unit.sv
// Moore control sequencer for the single-bus RISC datapath.
// Fetch T0-T2, opcode-driven execute T3-T6, halt and async-low clear.
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    output logic        PCin,
    output logic        PCout,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        MDMuxread,
    output logic        RAMread,
    output logic        RAMwrite,
    output logic        IRin,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        CSEout,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        OutPortin,
    output logic        ADD,
    output logic        SUB,
    output logic        MUL,
    output logic        DIV,
    output logic        AND,
    output logic        OR,
    output logic        SHR,
    output logic        SHRA,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic        Run
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3,
        S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_ALU, C_IMM, C_LDI,
        C_UN, C_MD, C_MF, C_HALT
    } cls_t;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_op;
    cls_t       w_cls;
    cls_t       w_ir_cls;

    function automatic cls_t f_cls(input logic [4:0] op);
        cls_t c;
        case (op)
            5'b00001: c = C_LDI;
            5'b00011, 5'b00100, 5'b00101,
            5'b00110, 5'b00111, 5'b01000,
            5'b01001, 5'b01010, 5'b01011: c = C_ALU;
            5'b01100, 5'b01101, 5'b01110: c = C_IMM;
            5'b01111, 5'b10000: c = C_MD;
            5'b10001, 5'b10010: c = C_UN;
            5'b11000, 5'b11001: c = C_MF;
            5'b11011: c = C_HALT;
            default: c = C_NONE;
        endcase
        return c;
    endfunction

    assign w_cls    = f_cls(r_op);
    assign w_ir_cls = f_cls(IR[31:27]);
    assign Run      = (r_state != S_HALT);

    // State register; opcode is latched only while leaving T2
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= S_RESET;
            r_op    <= 5'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_T2) begin
                r_op <= IR[31:27];
            end
        end
    end

    // Next-state sequencing by instruction class
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_RESET: w_next = S_T0;
            S_T0:    w_next = S_T1;
            S_T1:    w_next = S_T2;
            S_T2: begin
                if (w_ir_cls == C_NONE)
                    w_next = S_T0;
                else if (w_ir_cls == C_HALT)
                    w_next = S_HALT;
                else
                    w_next = S_T3;
            end
            S_T3: w_next = (w_cls == C_MF) ? S_T0 : S_T4;
            S_T4: w_next = (w_cls == C_UN) ? S_T0 : S_T5;
            S_T5: w_next = (w_cls == C_MD) ? S_T6 : S_T0;
            S_T6: w_next = S_T0;
            S_HALT: w_next = S_HALT;
            default: w_next = S_RESET;
        endcase
    end

    // Strobe decode from present state and latched opcode
    always_comb begin
        {PCin, PCout, MARin, MDRin, MDRout, MDMuxread,
         RAMread, RAMwrite, IRin, IncPC} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout, CSEout, Yin} = '0;
        {Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
         HIout, LOout, InPortout, OutPortin} = '0;
        {ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA,
         SHL, ROR, ROL, NEG, NOT} = '0;
        unique case (r_state)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            S_T1: begin
                Zlowout   = 1'b1;
                PCin      = 1'b1;
                MDMuxread = 1'b1;
                RAMread   = 1'b1;
                MDRin     = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                case (w_cls)
                    C_ALU, C_IMM: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    C_LDI: begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end
                    C_UN: begin
                        Grb    = 1'b1;
                        Rout   = 1'b1;
                        Zlowin = 1'b1;
                        NEG    = (r_op == 5'b10001);
                        NOT    = (r_op == 5'b10010);
                    end
                    C_MD: begin
                        Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    C_MF: begin
                        HIout = (r_op == 5'b11000);
                        LOout = (r_op == 5'b11001);
                        Gra   = 1'b1;
                        Rin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (w_cls)
                    C_ALU, C_IMM, C_LDI: begin
                        Grc    = (w_cls == C_ALU);
                        Rout   = (w_cls == C_ALU);
                        CSEout = (w_cls != C_ALU);
                        Zlowin = 1'b1;
                        case (r_op)
                            5'b00001, 5'b00011,
                            5'b01100: ADD  = 1'b1;
                            5'b00100: SUB  = 1'b1;
                            5'b00101,
                            5'b01101: AND  = 1'b1;
                            5'b00110,
                            5'b01110: OR   = 1'b1;
                            5'b00111: ROR  = 1'b1;
                            5'b01000: ROL  = 1'b1;
                            5'b01001: SHR  = 1'b1;
                            5'b01010: SHRA = 1'b1;
                            5'b01011: SHL  = 1'b1;
                            default: ;
                        endcase
                    end
                    C_UN: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    C_MD: begin
                        Grb     = 1'b1;
                        Rout    = 1'b1;
                        MUL     = (r_op == 5'b10000);
                        DIV     = (r_op == 5'b01111);
                        Zlowin  = 1'b1;
                        Zhighin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (w_cls == C_MD) begin
                    LOin = 1'b1;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit against a per-instruction
// table model of the expected strobe sequence.
module tb_control_unit;

    typedef bit [41:0] vec_t;
    typedef vec_t vq_t[$];

    localparam int I_PCin = 0, I_PCout = 1, I_MARin = 2;
    localparam int I_MDRin = 3, I_MDRout = 4, I_MDMux = 5;
    localparam int I_RAMread = 6, I_RAMwrite = 7, I_IRin = 8;
    localparam int I_IncPC = 9, I_Gra = 10, I_Grb = 11;
    localparam int I_Grc = 12, I_Rin = 13, I_Rout = 14;
    localparam int I_BAout = 15, I_CSEout = 16, I_Yin = 17;
    localparam int I_Zlowin = 18, I_Zhighin = 19;
    localparam int I_Zlowout = 20, I_Zhighout = 21;
    localparam int I_HIin = 22, I_LOin = 23, I_HIout = 24;
    localparam int I_LOout = 25, I_ADD = 28, I_SUB = 29;
    localparam int I_MUL = 30, I_DIV = 31, I_AND = 32;
    localparam int I_OR = 33, I_SHR = 34, I_SHRA = 35;
    localparam int I_SHL = 36, I_ROR = 37, I_ROL = 38;
    localparam int I_NEG = 39, I_NOT = 40, I_Run = 41;

    logic clock = 1'b0;
    logic clear;
    logic [31:0] IR;
    logic PCin, PCout, MARin, MDRin, MDRout, MDMuxread;
    logic RAMread, RAMwrite, IRin, IncPC;
    logic Gra, Grb, Grc, Rin, Rout, BAout, CSEout, Yin;
    logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic HIout, LOout, InPortout, OutPortin;
    logic ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL;
    logic ROR, ROL, NEG, NOT, Run;
    logic [41:0] act;

    int checks = 0;
    int failures = 0;
    vec_t exp_q[$];
    string tag_q[$];

    control_unit dut (
        .clock(clock), .clear(clear), .IR(IR),
        .PCin(PCin), .PCout(PCout), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout),
        .MDMuxread(MDMuxread), .RAMread(RAMread),
        .RAMwrite(RAMwrite), .IRin(IRin), .IncPC(IncPC),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .CSEout(CSEout),
        .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin),
        .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .LOin(LOin), .HIout(HIout),
        .LOout(LOout), .InPortout(InPortout),
        .OutPortin(OutPortin), .ADD(ADD), .SUB(SUB),
        .MUL(MUL), .DIV(DIV), .AND(AND), .OR(OR),
        .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR),
        .ROL(ROL), .NEG(NEG), .NOT(NOT), .Run(Run)
    );

    assign act = {Run, NOT, NEG, ROL, ROR, SHL, SHRA, SHR,
                  OR, AND, DIV, MUL, SUB, ADD, OutPortin,
                  InPortout, LOout, HIout, LOin, HIin,
                  Zhighout, Zlowout, Zhighin, Zlowin, Yin,
                  CSEout, BAout, Rout, Rin, Grc, Grb, Gra,
                  IncPC, IRin, RAMwrite, RAMread, MDMuxread,
                  MDRout, MDRin, MARin, PCout, PCin};

    always #5 clock = ~clock;

    function automatic vec_t b(input int i);
        vec_t v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // ALU select bit named by the opcode table
    function automatic int sel_of(input bit [4:0] op);
        case (op)
            5'b00001, 5'b00011, 5'b01100: return I_ADD;
            5'b00100: return I_SUB;
            5'b00101, 5'b01101: return I_AND;
            5'b00110, 5'b01110: return I_OR;
            5'b00111: return I_ROR;
            5'b01000: return I_ROL;
            5'b01001: return I_SHR;
            5'b01010: return I_SHRA;
            5'b01011: return I_SHL;
            5'b01111: return I_DIV;
            5'b10000: return I_MUL;
            5'b10001: return I_NEG;
            5'b10010: return I_NOT;
            default: return -1;
        endcase
    endfunction

    // Full cycle-by-cycle strobe list of one instruction
    function automatic vq_t model(input bit [4:0] op);
        vq_t q;
        vec_t r;
        r = b(I_Run);
        q.push_back(r | b(I_PCout) | b(I_MARin) | b(I_IncPC)
                    | b(I_Zlowin));
        q.push_back(r | b(I_Zlowout) | b(I_PCin) | b(I_MDMux)
                    | b(I_RAMread) | b(I_MDRin));
        q.push_back(r | b(I_MDRout) | b(I_IRin));
        if (op == 5'b00001) begin
            q.push_back(r | b(I_Grb) | b(I_BAout) | b(I_Yin));
            q.push_back(r | b(I_CSEout) | b(I_ADD) | b(I_Zlowin));
            q.push_back(r | b(I_Zlowout) | b(I_Gra) | b(I_Rin));
        end else if (op >= 5'b00011 && op <= 5'b01011) begin
            q.push_back(r | b(I_Grb) | b(I_Rout) | b(I_Yin));
            q.push_back(r | b(I_Grc) | b(I_Rout)
                        | b(sel_of(op)) | b(I_Zlowin));
            q.push_back(r | b(I_Zlowout) | b(I_Gra) | b(I_Rin));
        end else if (op >= 5'b01100 && op <= 5'b01110) begin
            q.push_back(r | b(I_Grb) | b(I_Rout) | b(I_Yin));
            q.push_back(r | b(I_CSEout) | b(sel_of(op))
                        | b(I_Zlowin));
            q.push_back(r | b(I_Zlowout) | b(I_Gra) | b(I_Rin));
        end else if (op == 5'b10001 || op == 5'b10010) begin
            q.push_back(r | b(I_Grb) | b(I_Rout) | b(sel_of(op))
                        | b(I_Zlowin));
            q.push_back(r | b(I_Zlowout) | b(I_Gra) | b(I_Rin));
        end else if (op == 5'b01111 || op == 5'b10000) begin
            q.push_back(r | b(I_Gra) | b(I_Rout) | b(I_Yin));
            q.push_back(r | b(I_Grb) | b(I_Rout) | b(sel_of(op))
                        | b(I_Zlowin) | b(I_Zhighin));
            q.push_back(r | b(I_Zlowout) | b(I_LOin));
            q.push_back(r | b(I_Zhighout) | b(I_HIin));
        end else if (op == 5'b11000 || op == 5'b11001) begin
            q.push_back(r | b(op[0] ? I_LOout : I_HIout)
                        | b(I_Gra) | b(I_Rin));
        end
        return q;
    endfunction

    task automatic push(input vec_t v, input string t);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    // Drive an instruction; IR is junk except during T2
    task automatic run_instr(input bit [4:0] op, input int upto);
        vq_t q;
        q = model(op);
        for (int k = 0; k < q.size() && k < upto; k++) begin
            @(posedge clock);
            #1;
            if (k == 2)
                IR = {op, 27'($urandom)};
            else
                IR = $urandom;
            push(q[k], $sformatf("op%05b_T%0d", op, k));
        end
    endtask

    task automatic do_reset(input int n, input bit mid);
        @(posedge clock);
        if (mid) #3;
        else #1;
        clear = 1'b0;
        push(b(I_Run), "reset");
        for (int k = 1; k < n; k++) begin
            @(posedge clock);
            #1;
            push(b(I_Run), "reset");
        end
        @(posedge clock);
        #1;
        clear = 1'b1;
        push(b(I_Run), "reset_rel");
    endtask

    task automatic pin(input string t, input int got,
                       input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", t, got, want);
        end
    endtask

    // Single compare process on the falling edge
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s act=%h exp=%h", t, act, e);
            end
        end
    end

    initial begin
        vq_t q;
        bit [4:0] op;
        clear = 1'b1;
        IR = '0;
        #1 clear = 1'b0;

        q = model(5'b11010);
        pin("lat_nop", q.size(), 3);
        q = model(5'b11000);
        pin("lat_mfhi", q.size(), 4);
        q = model(5'b10001);
        pin("lat_neg", q.size(), 5);
        q = model(5'b01101);
        pin("lat_andi", q.size(), 6);
        q = model(5'b10000);
        pin("lat_mul", q.size(), 7);
        q = model(5'b00011);
        pin("add_T4", int'(q[4][31:0]),
            int'(32'h1004_5000));

        do_reset(2, 1'b0);
        run_instr(5'b00001, 99);
        run_instr(5'b01101, 99);
        run_instr(5'b00011, 99);
        run_instr(5'b10000, 99);
        run_instr(5'b01111, 99);
        run_instr(5'b11001, 99);
        run_instr(5'b10010, 99);
        run_instr(5'b11111, 99);

        for (int n = 0; n < 300; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b11010;
            run_instr(op, 99);
        end

        run_instr(5'b00011, 4);
        do_reset(2, 1'b1);
        run_instr(5'b00011, 99);

        run_instr(5'b11011, 99);
        for (int k = 0; k < 12; k++) begin
            @(posedge clock);
            #1;
            IR = $urandom;
            push('0, "halt");
        end
        do_reset(1, 1'b0);
        run_instr(5'b11010, 99);
        run_instr(5'b00110, 99);

        repeat (3) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
